// File: rtl/sprf_idx_pipe.sv
// SPRF front end: NCH index registers, stall-able type/read-select delay line and
// indirect DRAM address generation with circular post-increment/decrement.
module sprf_idx_pipe #(
    parameter int NCH      = 2,
    parameter int TYP_W    = 2,
    parameter int DAT_W    = 16,
    parameter int ADDR_W   = 10,
    parameter int ADDR_LIM = 1024,
    parameter int SEL_DLY  = 2,
    parameter int STEP_W   = 4,
    parameter int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   reset_b,
    input  logic                   t_cs,
    input  logic [NCH*TYP_W-1:0]   typ_sel_i,
    input  logic [NCH-1:0]         rd_sel_src_i,
    input  logic [NCH-1:0]         rd_sel_dst_i,
    input  logic                   wr_en_i,
    input  logic [CH_W-1:0]        wr_ch_i,
    input  logic [DAT_W-1:0]       wr_dat_i,
    input  logic                   src_indir_i,
    input  logic                   dst_indir_i,
    input  logic [CH_W-1:0]        indir_ch_i,
    input  logic [1:0]             pm_mode_i,
    input  logic [STEP_W-1:0]      pm_step_i,
    output logic [NCH*TYP_W-1:0]   typ_sel_o,
    output logic [NCH-1:0]         rd_sel_o,
    output logic [NCH*DAT_W-1:0]   idx_o,
    output logic [ADDR_W-1:0]      dram_addr_o,
    output logic                   dram_addr_vld_o
);

    // Wide enough to hold v+s and ADDR_LIM (up to 2^ADDR_W) without overflow.
    localparam int PW = ((ADDR_W > STEP_W) ? ADDR_W : STEP_W) + 2;

    logic [SEL_DLY-1:0][NCH*TYP_W-1:0] r_typ_pipe;
    logic [NCH-1:0]                    r_rd_sel;
    logic                              r_req_a;
    logic [CH_W-1:0]                   r_ch_a;
    logic [1:0]                        r_pm_a;
    logic [STEP_W-1:0]                 r_step_a;
    logic [ADDR_W-1:0]                 r_dram_addr;
    logic                              r_dram_vld;

    logic [NCH-1:0]                    w_hit;
    logic [ADDR_W-1:0]                 w_v;
    logic [PW-1:0]                     w_v_ext;
    logic [PW-1:0]                     w_s_ext;
    logic [PW-1:0]                     w_lim;
    logic [PW-1:0]                     w_sum;
    logic [ADDR_W-1:0]                 w_inc;
    logic [ADDR_W-1:0]                 w_dec;
    logic [ADDR_W-1:0]                 w_pm_res;
    logic                              w_fire;
    logic                              w_pm_en;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_typ_pipe <= '0;
            r_rd_sel   <= '0;
        end else if (t_cs) begin
            r_typ_pipe[0] <= typ_sel_i;
            for (int k = 1; k < SEL_DLY; k++) begin
                r_typ_pipe[k] <= r_typ_pipe[k-1];
            end
            r_rd_sel <= rd_sel_src_i | rd_sel_dst_i;
        end
    end

    assign typ_sel_o = r_typ_pipe[SEL_DLY-1];
    assign rd_sel_o  = r_rd_sel;

    // Stage A samples every cycle; t_cs only gates whether stage B acts on it.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_req_a  <= 1'b0;
            r_ch_a   <= '0;
            r_pm_a   <= 2'b00;
            r_step_a <= '0;
        end else begin
            r_req_a  <= src_indir_i | dst_indir_i;
            r_ch_a   <= indir_ch_i;
            r_pm_a   <= pm_mode_i;
            r_step_a <= pm_step_i;
        end
    end

    // Channel decode by equality so an out-of-range channel simply hits nothing.
    always_comb begin
        w_v = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_hit[c]) begin
                w_v = w_v | idx_o[c*DAT_W +: ADDR_W];
            end
        end
    end

    assign w_fire  = t_cs & r_req_a & (|w_hit);
    assign w_pm_en = w_fire & ((r_pm_a == 2'b01) | (r_pm_a == 2'b10));

    assign w_v_ext  = PW'(w_v);
    assign w_s_ext  = PW'(r_step_a);
    assign w_lim    = PW'(ADDR_LIM);
    assign w_sum    = w_v_ext + w_s_ext;
    assign w_inc    = (w_sum >= w_lim) ? ADDR_W'(w_sum - w_lim) : ADDR_W'(w_sum);
    assign w_dec    = (w_v_ext < w_s_ext) ? ADDR_W'(w_v_ext + w_lim - w_s_ext)
                                          : ADDR_W'(w_v_ext - w_s_ext);
    assign w_pm_res = (r_pm_a == 2'b01) ? w_inc : w_dec;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DAT_W-1:0] r_idx;

            assign w_hit[gi] = (r_ch_a == CH_W'(gi));
            assign idx_o[gi*DAT_W +: DAT_W] = r_idx;

            // A register write on the same edge takes priority over post-modify.
            always_ff @(posedge clk or negedge reset_b) begin
                if (!reset_b) begin
                    r_idx <= '0;
                end else if (t_cs && wr_en_i && (wr_ch_i == CH_W'(gi))) begin
                    r_idx <= wr_dat_i;
                end else if (w_pm_en && w_hit[gi]) begin
                    r_idx <= DAT_W'(w_pm_res);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_dram_addr <= '0;
            r_dram_vld  <= 1'b0;
        end else begin
            r_dram_addr <= w_fire ? w_v : '0;
            r_dram_vld  <= w_fire;
        end
    end

    assign dram_addr_o     = r_dram_addr;
    assign dram_addr_vld_o = r_dram_vld;

endmodule

// File: tb/tb_sprf_idx_pipe.sv
// Directed bench for sprf_idx_pipe: select delay/stall, indirect addressing,
// circular post-modify, write priority, stall drop and mid-flight reset.
module tb_sprf_idx_pipe;

    logic        clk;
    logic        reset_b;
    logic        t_cs;
    logic [3:0]  typ_sel_i;
    logic [1:0]  rd_sel_src_i;
    logic [1:0]  rd_sel_dst_i;
    logic        wr_en_i;
    logic [0:0]  wr_ch_i;
    logic [15:0] wr_dat_i;
    logic        src_indir_i;
    logic        dst_indir_i;
    logic [0:0]  indir_ch_i;
    logic [1:0]  pm_mode_i;
    logic [3:0]  pm_step_i;
    logic [3:0]  typ_sel_o;
    logic [1:0]  rd_sel_o;
    logic [31:0] idx_o;
    logic [9:0]  dram_addr_o;
    logic        dram_addr_vld_o;

    int checks_cnt;
    int errors_cnt;

    sprf_idx_pipe dut (
        .clk             (clk),
        .reset_b         (reset_b),
        .t_cs            (t_cs),
        .typ_sel_i       (typ_sel_i),
        .rd_sel_src_i    (rd_sel_src_i),
        .rd_sel_dst_i    (rd_sel_dst_i),
        .wr_en_i         (wr_en_i),
        .wr_ch_i         (wr_ch_i),
        .wr_dat_i        (wr_dat_i),
        .src_indir_i     (src_indir_i),
        .dst_indir_i     (dst_indir_i),
        .indir_ch_i      (indir_ch_i),
        .pm_mode_i       (pm_mode_i),
        .pm_step_i       (pm_step_i),
        .typ_sel_o       (typ_sel_o),
        .rd_sel_o        (rd_sel_o),
        .idx_o           (idx_o),
        .dram_addr_o     (dram_addr_o),
        .dram_addr_vld_o (dram_addr_vld_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        checks_cnt++;
        if (obs !== exp_val) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_val);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input logic [0:0] ch, input logic [1:0] mode, input logic [3:0] s);
        src_indir_i = 1'b1;
        indir_ch_i  = ch;
        pm_mode_i   = mode;
        pm_step_i   = s;
    endtask

    task automatic no_req();
        src_indir_i = 1'b0;
        dst_indir_i = 1'b0;
        pm_mode_i   = 2'b00;
        pm_step_i   = 4'd0;
    endtask

    task automatic wr(input logic [0:0] ch, input logic [15:0] dat);
        wr_en_i  = 1'b1;
        wr_ch_i  = ch;
        wr_dat_i = dat;
    endtask

    initial begin
        checks_cnt   = 0;
        errors_cnt   = 0;
        reset_b      = 1'b0;
        t_cs         = 1'b0;
        typ_sel_i    = '0;
        rd_sel_src_i = '0;
        rd_sel_dst_i = '0;
        wr_en_i      = 1'b0;
        wr_ch_i      = '0;
        wr_dat_i     = '0;
        indir_ch_i   = '0;
        no_req();
        step();
        step();
        chk("rst_typ", 32'(typ_sel_o), 32'h0);
        chk("rst_idx", idx_o, 32'h0);
        chk("rst_vld", 32'(dram_addr_vld_o), 32'h0);
        reset_b = 1'b1;
        t_cs    = 1'b1;
        step();

        // Type-select delay of 2 advancing cycles
        typ_sel_i = 4'b0010;
        step();
        typ_sel_i = 4'b0000;
        chk("typ_d1", 32'(typ_sel_o), 32'h0);
        step();
        chk("typ_d2", 32'(typ_sel_o), 32'h2);
        step();
        chk("typ_d3", 32'(typ_sel_o), 32'h0);

        // Three stall cycles stretch the delay by exactly three
        typ_sel_i = 4'b0110;
        step();
        typ_sel_i = 4'b0000;
        t_cs = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("typ_stall", 32'(typ_sel_o), 32'h0);
        end
        t_cs = 1'b1;
        step();
        chk("typ_after_stall", 32'(typ_sel_o), 32'h6);

        // Read-select OR and hold
        rd_sel_src_i = 2'b01;
        rd_sel_dst_i = 2'b10;
        step();
        chk("rd_or", 32'(rd_sel_o), 32'h3);
        rd_sel_src_i = 2'b00;
        rd_sel_dst_i = 2'b00;
        t_cs = 1'b0;
        step();
        chk("rd_hold", 32'(rd_sel_o), 32'h3);
        t_cs = 1'b1;
        step();
        chk("rd_clear", 32'(rd_sel_o), 32'h0);

        // Indirect with +3, back to back on channel 1
        wr(1'b1, 16'h0005);
        step();
        wr_en_i = 1'b0;
        chk("wr_idx1", 32'(idx_o[31:16]), 32'h5);
        req(1'b1, 2'b01, 4'd3);
        step();
        chk("ind_lat1_vld", 32'(dram_addr_vld_o), 32'h0);
        step();
        no_req();
        chk("ind1_addr", 32'(dram_addr_o), 32'd5);
        chk("ind1_vld", 32'(dram_addr_vld_o), 32'h1);
        chk("ind1_idx", 32'(idx_o[31:16]), 32'd8);
        step();
        chk("ind2_addr", 32'(dram_addr_o), 32'd8);
        chk("ind2_vld", 32'(dram_addr_vld_o), 32'h1);
        chk("ind2_idx", 32'(idx_o[31:16]), 32'd11);
        step();
        chk("ind_idle_vld", 32'(dram_addr_vld_o), 32'h0);
        chk("ind_idle_addr", 32'(dram_addr_o), 32'h0);

        // Circular wrap up and down on channel 0
        wr(1'b0, 16'd1022);
        step();
        wr_en_i = 1'b0;
        req(1'b0, 2'b01, 4'd4);
        step();
        no_req();
        step();
        chk("wrap_up_addr", 32'(dram_addr_o), 32'd1022);
        chk("wrap_up_idx", 32'(idx_o[15:0]), 32'd2);
        wr(1'b0, 16'd1);
        step();
        wr_en_i = 1'b0;
        req(1'b0, 2'b10, 4'd3);
        step();
        no_req();
        step();
        chk("wrap_dn_addr", 32'(dram_addr_o), 32'd1);
        chk("wrap_dn_idx", 32'(idx_o[15:0]), 32'd1022);

        // Write and post-modify on the same channel: write wins, address is old value
        req(1'b0, 2'b01, 4'd1);
        step();
        no_req();
        wr(1'b0, 16'h0100);
        step();
        wr_en_i = 1'b0;
        chk("same_ch_addr", 32'(dram_addr_o), 32'd1022);
        chk("same_ch_idx", 32'(idx_o[15:0]), 32'h0100);

        // Write ch0 and post-modify ch1 together: both happen
        req(1'b1, 2'b01, 4'd1);
        step();
        no_req();
        wr(1'b0, 16'h0200);
        step();
        wr_en_i = 1'b0;
        chk("diff_ch_addr", 32'(dram_addr_o), 32'd11);
        chk("diff_ch_idx", idx_o, {16'd12, 16'h0200});

        // Stall at stage B drops the request
        req(1'b1, 2'b01, 4'd2);
        step();
        step();
        no_req();
        chk("pre_stall_addr", 32'(dram_addr_o), 32'd12);
        chk("pre_stall_idx", 32'(idx_o[31:16]), 32'd14);
        t_cs = 1'b0;
        step();
        chk("stall_drop_addr", 32'(dram_addr_o), 32'h0);
        chk("stall_drop_vld", 32'(dram_addr_vld_o), 32'h0);
        chk("stall_drop_idx", 32'(idx_o[31:16]), 32'd14);
        t_cs = 1'b1;

        // Reset while a request sits in stage A
        typ_sel_i    = 4'b1001;
        rd_sel_src_i = 2'b11;
        step();
        typ_sel_i    = 4'b0000;
        rd_sel_src_i = 2'b00;
        req(1'b1, 2'b01, 4'd1);
        step();
        no_req();
        reset_b = 1'b0;
        #1;
        chk("arst_idx", idx_o, 32'h0);
        chk("arst_typ", 32'(typ_sel_o), 32'h0);
        chk("arst_rd", 32'(rd_sel_o), 32'h0);
        chk("arst_vld", 32'(dram_addr_vld_o), 32'h0);
        step();
        reset_b = 1'b1;
        step();
        chk("post_rst_vld", 32'(dram_addr_vld_o), 32'h0);
        step();
        chk("post_rst_vld2", 32'(dram_addr_vld_o), 32'h0);
        chk("post_rst_addr", 32'(dram_addr_o), 32'h0);
        chk("post_rst_idx", idx_o, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
